fifo_read_serializer: RTL and testbench

FIFO_READ_SERIALIZER -- requirements
Module: fifo_read_serializer

---
 rtl/fifo_read_serializer_pkg.sv | 15 +
 rtl/fifo_read_serializer_bit_timer.sv | 39 +++
 rtl/fifo_read_serializer.sv | 93 +++++++++
 tb/tb_fifo_read_serializer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_serializer_pkg.sv
// Shared definitions for the FIFO read serializer.
// State encoding and default geometry.
package fifo_read_serializer_pkg;

   localparam int DATA_SIZE_DEF = 8;
   localparam int CLK_DIV_DEF   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_read_serializer_bit_timer.sv
// Bit period divider for the serializer.
// Marks the first and last read_clk cycle of every bit.
module bit_timer
   import fifo_read_serializer_pkg::*;
#(
   parameter int clk_div = CLK_DIV_DEF
) (
   input  logic read_clk,
   input  logic read_reset_n,
   input  logic reload,
   input  logic run,
   output logic bit_strobe,
   output logic bit_end
);

   localparam int DIV_W = $clog2(clk_div);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(clk_div - 1);

   logic [DIV_W-1:0] div_cnt;

   // Count read_clk cycles within the current bit, restarting each byte.
   always_ff @(posedge read_clk or negedge read_reset_n) begin
      if (!read_reset_n) begin
         div_cnt <= '0;
      end else if (reload) begin
         div_cnt <= '0;
      end else if (run) begin
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   assign bit_strobe = run && (div_cnt == '0);
   assign bit_end    = run && (div_cnt == DIV_LAST);

endmodule

// File: rtl/fifo_read_serializer.sv
// Pops FIFO entries and shifts them out MSB first.
// FSM, shift register and byte counter live here.
module fifo_read_serializer
   import fifo_read_serializer_pkg::*;
#(
   parameter int data_size = DATA_SIZE_DEF,
   parameter int clk_div   = CLK_DIV_DEF
) (
   input  logic                 read_clk,
   input  logic                 read_reset_n,
   input  logic [data_size-1:0] read_data,
   input  logic                 read_empty,
   output logic                 read_enable,
   input  logic                 enable,
   output logic                 serial_data,
   output logic                 serial_valid,
   output logic                 bit_strobe,
   output logic                 byte_done,
   output logic                 busy,
   output logic [15:0]          bytes_sent
);

   localparam int BIT_W = $clog2(data_size);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(data_size - 1);

   state_t               state;
   logic [data_size-1:0] shift_q;
   logic [BIT_W-1:0]     bit_cnt;
   logic [15:0]          bytes_sent_q;
   logic                 start_ok;
   logic                 bit_end;
   logic                 tick;

   assign start_ok = enable && !read_empty;

   bit_timer #(
      .clk_div(clk_div)
   ) u_bit_timer (
      .read_clk    (read_clk),
      .read_reset_n(read_reset_n),
      .reload      (state == LOAD),
      .run         (state == SHIFT),
      .bit_strobe  (tick),
      .bit_end     (bit_end)
   );

   // Byte sequencing: pop, shift out, count, then decide on the next byte.
   always_ff @(posedge read_clk or negedge read_reset_n) begin
      if (!read_reset_n) begin
         state        <= IDLE;
         shift_q      <= '0;
         bit_cnt      <= '0;
         bytes_sent_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_ok) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               shift_q <= read_data;
               bit_cnt <= '0;
               state   <= SHIFT;
            end
            SHIFT: begin
               if (bit_end) begin
                  if (bit_cnt == BIT_LAST) begin
                     state <= DONE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shift_q <= {shift_q[data_size-2:0], 1'b0};
                  end
               end
            end
            DONE: begin
               bytes_sent_q <= bytes_sent_q + 16'd1;
               state        <= start_ok ? LOAD : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign read_enable  = (state == LOAD);
   assign busy         = (state != IDLE);
   assign byte_done    = (state == DONE);
   assign serial_valid = (state == SHIFT);
   assign serial_data  = (state == SHIFT) ? shift_q[data_size-1] : 1'b1;
   assign bit_strobe   = tick;
   assign bytes_sent   = bytes_sent_q;

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Self-checking bench for fifo_read_serializer (8-bit, divide by 4).
// Directed vectors plus random traffic against a cycle-phase model.
module tb_fifo_read_serializer;

   logic        read_clk     = 1'b0;
   logic        read_reset_n = 1'b1;
   logic [7:0]  read_data    = 8'h00;
   logic        read_empty   = 1'b1;
   logic        enable       = 1'b0;
   logic        read_enable;
   logic        serial_data;
   logic        serial_valid;
   logic        bit_strobe;
   logic        byte_done;
   logic        busy;
   logic [15:0] bytes_sent;

   int n_checks = 0;
   int n_fail   = 0;

   fifo_read_serializer #(
      .data_size(8),
      .clk_div  (4)
   ) dut (
      .read_clk    (read_clk),
      .read_reset_n(read_reset_n),
      .read_data   (read_data),
      .read_empty  (read_empty),
      .read_enable (read_enable),
      .enable      (enable),
      .serial_data (serial_data),
      .serial_valid(serial_valid),
      .bit_strobe  (bit_strobe),
      .byte_done   (byte_done),
      .busy        (busy),
      .bytes_sent  (bytes_sent)
   );

   always #5 read_clk = ~read_clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // FIFO model: registered empty flag and head, pop on read_enable.
   logic [7:0] fq[$];
   int         pops = 0;
   always @(posedge read_clk) begin
      if (read_enable && fq.size() != 0) begin
         void'(fq.pop_front());
         pops++;
      end
      read_empty <= (fq.size() == 0);
      read_data  <= (fq.size() != 0) ? fq[0] : 8'h00;
   end

   // Reference: phase within a byte (-1 idle, 0 pop, 1..32 bits, 33 done).
   int          ph    = -1;
   logic [7:0]  cur   = 8'h00;
   logic [15:0] msent = 16'h0000;
   always @(posedge read_clk or negedge read_reset_n) begin
      if (!read_reset_n) begin
         ph    = -1;
         msent = 16'h0000;
      end else if (ph == -1 || ph == 33) begin
         if (ph == 33) msent = msent + 16'd1;
         ph = (enable && !read_empty) ? 0 : -1;
      end else begin
         if (ph == 0) cur = read_data;
         ph = ph + 1;
      end
   end

   // Per-cycle comparison and receive capture on the falling edge.
   logic       chk_en   = 1'b0;
   logic       sh;
   int         bidx;
   logic       e_d;
   logic [5:0] e_out;
   logic [7:0] cap      = 8'h00;
   logic [7:0] rx[$];
   int         gapcnt   = 0;
   int         last_gap = -1;
   always @(negedge read_clk) begin
      if (chk_en) begin
         sh    = (ph >= 1) && (ph <= 32);
         bidx  = sh ? (ph - 1) / 4 : 0;
         e_d   = sh ? cur[7 - bidx] : 1'b1;
         e_out = {ph == 0, ph != -1, sh, e_d,
                  sh && ((ph - 1) % 4 == 0), ph == 33};
         check("cycle_outputs",
               {26'd0, read_enable, busy, serial_valid,
                serial_data, bit_strobe, byte_done},
               {26'd0, e_out});
         check("bytes_sent_model", {16'd0, bytes_sent}, {16'd0, msent});
         check("pop_when_empty", {31'd0, read_enable & read_empty}, 32'd0);
      end
      if (bit_strobe) cap = {cap[6:0], serial_data};
      if (byte_done) rx.push_back(cap);
      if (serial_valid) begin
         if (gapcnt > 0) last_gap = gapcnt;
         gapcnt = 0;
      end else begin
         gapcnt++;
      end
   end

   typedef struct {
      logic [7:0] data;
      logic [7:0] exp_bits;
      int         exp_re_cyc;
      int         exp_done_cyc;
   } vec_t;

   vec_t        vt[5];
   logic [7:0]  pushed[$];
   int          exp_count;
   int          p0;
   int          n0;
   int          re_cyc;
   int          dn_cyc;
   int          cnt;
   logic [7:0]  d;

   task automatic cycles(input int n);
      repeat (n) @(negedge read_clk);
   endtask

   task automatic rx_check(input string name, input int idx,
                           input logic [7:0] exp);
      if (rx.size() > idx) check(name, {24'd0, rx[idx]}, {24'd0, exp});
      else check({name, "_missing"}, 32'd0, 32'd1);
   endtask

   initial begin
      vt[0] = '{8'hA5, 8'b1010_0101, 1, 34};
      vt[1] = '{8'h00, 8'b0000_0000, 1, 34};
      vt[2] = '{8'hFF, 8'b1111_1111, 1, 34};
      vt[3] = '{8'h81, 8'b1000_0001, 1, 34};
      vt[4] = '{8'h6E, 8'b0110_1110, 1, 34};
      exp_count = 0;

      #1 read_reset_n = 1'b0;
      chk_en = 1'b1;
      #1;
      check("reset_state",
            {11'd0, serial_data, serial_valid, read_enable, busy,
             bit_strobe, byte_done, bytes_sent},
            {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
      cycles(2);
      read_reset_n = 1'b1;
      cycles(2);

      for (int i = 0; i < 5; i++) begin
         p0 = pops;
         n0 = rx.size();
         fq.push_back(vt[i].data);
         @(negedge read_clk);
         enable = 1'b1;
         re_cyc = 0;
         dn_cyc = 0;
         for (int c = 1; c <= 40; c++) begin
            @(negedge read_clk);
            if (c == 1) enable = 1'b0;
            if (read_enable && re_cyc == 0) re_cyc = c;
            if (byte_done && dn_cyc == 0) dn_cyc = c;
         end
         exp_count++;
         check("vec_pop_cycle", re_cyc, vt[i].exp_re_cyc);
         check("vec_done_cycle", dn_cyc, vt[i].exp_done_cyc);
         rx_check("vec_bits", n0, vt[i].exp_bits);
         check("vec_pops", pops - p0, 1);
         check("vec_bytes_sent", {16'd0, bytes_sent}, exp_count);
      end

      p0 = pops;
      enable = 1'b1;
      cnt = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge read_clk);
         if (read_enable || busy) cnt++;
      end
      enable = 1'b0;
      check("empty_stays_idle", cnt, 0);
      check("empty_no_pop", pops - p0, 0);

      p0 = pops;
      n0 = rx.size();
      fq.push_back(8'h3C);
      fq.push_back(8'hC3);
      @(negedge read_clk);
      enable = 1'b1;
      cnt = 0;
      while (rx.size() < n0 + 2 && cnt < 120) begin
         @(negedge read_clk);
         cnt++;
      end
      enable = 1'b0;
      cycles(3);
      exp_count += 2;
      check("b2b_timeout", {31'd0, cnt < 120}, 32'd1);
      rx_check("b2b_first", n0, 8'h3C);
      rx_check("b2b_second", n0 + 1, 8'hC3);
      check("b2b_gap", last_gap, 2);
      check("b2b_pops", pops - p0, 2);
      check("b2b_bytes_sent", {16'd0, bytes_sent}, exp_count);

      p0 = pops;
      n0 = rx.size();
      fq.push_back(8'hF0);
      fq.push_back(8'h0F);
      @(negedge read_clk);
      enable = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge read_clk);
         if (c == 14) enable = 1'b0;
      end
      exp_count++;
      rx_check("drop_byte", n0, 8'hF0);
      check("drop_pops", pops - p0, 1);
      check("drop_left", fq.size(), 1);
      if (fq.size() != 0) check("drop_head", {24'd0, fq[0]}, 32'h0F);
      check("drop_idle", {31'd0, busy}, 32'd0);
      check("drop_bytes_sent", {16'd0, bytes_sent}, exp_count);
      fq.delete();
      cycles(2);

      @(negedge read_clk);
      #2;
      force dut.bytes_sent_q = 16'hFFFF;
      msent = 16'hFFFF;
      #1 release dut.bytes_sent_q;
      @(negedge read_clk);
      check("wrap_preload", {16'd0, bytes_sent}, 32'h0000FFFF);
      fq.push_back(8'h5A);
      @(negedge read_clk);
      enable = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge read_clk);
         if (c == 1) enable = 1'b0;
      end
      exp_count = 0;
      check("wrap_bytes_sent", {16'd0, bytes_sent}, 32'd0);

      n0 = rx.size();
      pushed.delete();
      for (int c = 0; c < 500; c++) begin
         @(negedge read_clk);
         if ($urandom_range(0, 5) == 0) begin
            d = 8'($urandom);
            fq.push_back(d);
            pushed.push_back(d);
         end
         enable = ($urandom_range(0, 3) != 0);
      end
      enable = 1'b0;
      cnt = 0;
      while (busy && cnt < 60) begin
         @(negedge read_clk);
         cnt++;
      end
      cycles(2);
      check("rnd_drain", {31'd0, busy}, 32'd0);
      check("rnd_count", rx.size() - n0 + fq.size(), pushed.size());
      for (int i = 0; i < rx.size() - n0 && i < pushed.size(); i++) begin
         check("rnd_byte", {24'd0, rx[n0 + i]}, {24'd0, pushed[i]});
      end
      exp_count += rx.size() - n0;
      check("rnd_bytes_sent", {16'd0, bytes_sent}, exp_count & 32'hFFFF);
      fq.delete();
      cycles(2);

      p0 = pops;
      fq.push_back(8'hA5);
      @(negedge read_clk);
      enable = 1'b1;
      cycles(10);
      #2 read_reset_n = 1'b0;
      #1;
      check("reset_async",
            {12'd0, serial_data, serial_valid, read_enable, busy, bytes_sent},
            {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
      enable = 1'b0;
      cycles(2);
      read_reset_n = 1'b1;
      cycles(5);
      check("reset_no_repop", pops - p0, 1);
      check("reset_idle", {31'd0, busy}, 32'd0);
      check("reset_entry_lost", {31'd0, read_empty}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected end");
      $fatal(1, "watchdog");
   end

endmodule
